// File: rtl/microwave_pkg.sv
// Shared types, constants and helper functions for the microwave oven controller.
package microwave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COOK,
        ST_PAUSE,
        ST_DONE
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;
    localparam int unsigned KEY_W   = 10;

    // True when exactly one key bit is set.
    function automatic logic key_is_onehot(input logic [KEY_W-1:0] k);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            if (k[i]) cnt++;
        end
        return (cnt == 1);
    endfunction

    // One-hot key vector to BCD digit; meaningful only for one-hot inputs.
    function automatic logic [3:0] key_to_bcd(input logic [KEY_W-1:0] k);
        logic [3:0] d;
        d = '0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            if (k[i]) d = 4'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/mw_tick_gen.sv
// Countdown prescaler: pulses tick for one cycle every TICK_DIV enabled cycles.
module mw_tick_gen #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    // Prescaler counter, held at zero while cleared, wraps after the last count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) cnt <= '0;
            else             cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/microwave_controller.sv
// Microwave oven sequencing FSM: keypad M:SS entry, 1 s BCD countdown, magnetron and done control.
module microwave_controller
    import microwave_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [KEY_W-1:0] keypad,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clearn,
    input  logic             door_closed,
    output logic [3:0]       mins,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             mag_on,
    output logic             timer_done
);

    state_t           state;
    logic [KEY_W-1:0] key_q;
    logic             start_q;
    logic             stop_q;
    logic             clr_q;
    logic             door_q;

    logic             key_ev;
    logic             start_ev;
    logic             stop_ev;
    logic             clr_ev;
    logic             door_fall;
    logic [3:0]       key_d;
    logic             tick;
    logic             time_zero;

    logic [3:0]       dec_m;
    logic [3:0]       dec_t;
    logic [3:0]       dec_o;
    logic             dec_zero;

    // Prescaler runs only in COOK and restarts from zero on every COOK entry.
    mw_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .resetn(resetn),
        .en    (state == ST_COOK),
        .clr   (state != ST_COOK),
        .tick  (tick)
    );

    // Previous-value registers for edge detection; reset to the released level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_q   <= '0;
            start_q <= 1'b1;
            stop_q  <= 1'b1;
            clr_q   <= 1'b1;
            door_q  <= door_closed;
        end else begin
            key_q   <= keypad;
            start_q <= startn;
            stop_q  <= stopn;
            clr_q   <= clearn;
            door_q  <= door_closed;
        end
    end

    // Single-cycle events and key decode.
    always_comb begin
        start_ev  = start_q && !startn;
        stop_ev   = stop_q && !stopn;
        clr_ev    = clr_q && !clearn;
        door_fall = door_q && !door_closed;
        key_ev    = (key_q == '0) && key_is_onehot(keypad);
        key_d     = key_to_bcd(keypad);
        time_zero = (mins == '0) && (tens == '0) && (ones == '0);
    end

    // One-second BCD decrement; tens refills to 5 only when borrowing from minutes.
    always_comb begin
        dec_m = mins;
        dec_t = tens;
        dec_o = ones;
        if (ones != '0) begin
            dec_o = ones - 4'd1;
        end else if (tens != '0) begin
            dec_t = tens - 4'd1;
            dec_o = BCD_NINE;
        end else begin
            dec_m = mins - 4'd1;
            dec_t = BCD_FIVE;
            dec_o = BCD_NINE;
        end
        dec_zero = (dec_m == '0) && (dec_t == '0) && (dec_o == '0);
    end

    // Main sequencing FSM with registered digit and status outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            mins       <= '0;
            tens       <= '0;
            ones       <= '0;
            mag_on     <= 1'b0;
            timer_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Stop consumes the cycle; an open door only blocks start, not key entry.
                    if (clr_ev) begin
                        mins <= '0;
                        tens <= '0;
                        ones <= '0;
                    end else if (stop_ev) begin
                        state <= ST_IDLE;
                    end else if (start_ev) begin
                        if (door_closed && !time_zero) begin
                            state  <= ST_COOK;
                            mag_on <= 1'b1;
                        end
                    end else if (key_ev) begin
                        mins <= tens;
                        tens <= ones;
                        ones <= key_d;
                    end
                end
                ST_COOK: begin
                    if (clr_ev) begin
                        state  <= ST_IDLE;
                        mag_on <= 1'b0;
                        mins   <= '0;
                        tens   <= '0;
                        ones   <= '0;
                    end else if (stop_ev || !door_closed) begin
                        state  <= ST_PAUSE;
                        mag_on <= 1'b0;
                    end else if (tick) begin
                        if (dec_zero) begin
                            state      <= ST_DONE;
                            mag_on     <= 1'b0;
                            timer_done <= 1'b1;
                            mins       <= '0;
                            tens       <= '0;
                            ones       <= '0;
                        end else begin
                            mins <= dec_m;
                            tens <= dec_t;
                            ones <= dec_o;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (clr_ev || stop_ev) begin
                        state <= ST_IDLE;
                        mins  <= '0;
                        tens  <= '0;
                        ones  <= '0;
                    end else if (start_ev && door_closed) begin
                        state  <= ST_COOK;
                        mag_on <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (clr_ev || stop_ev || start_ev || key_ev || door_fall) begin
                        state      <= ST_IDLE;
                        timer_done <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    mag_on     <= 1'b0;
                    timer_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
